// File: rtl/reg_exec_seq.sv
// Execute sequencer beside the 8x16 register file: fetch two operands, compute,
// write the result back. One instruction every four cycles (longer for SHL).
module reg_exec_seq #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    input  logic [WIDTH-1:0] d_out_a,
    input  logic [WIDTH-1:0] d_out_b,
    output logic             wr,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] d_in,
    output logic             done,
    output logic             flag_z,
    output logic             flag_c
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic [3:0]        count_q, count_d;
    logic [AW-1:0]     rda_q, rda_d, rdb_q, rdb_d, wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  d_in_q, d_in_d;
    logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic [WIDTH:0]    sum_s;

    assign sum_s = {1'b0, opa_q} + {1'b0, opb_q};

    // Next-state and datapath for the IDLE/READ/EXEC/WB sequence
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        carry_d   = carry_q;
        count_d   = count_q;
        rda_d     = rda_q;
        rdb_d     = rdb_q;
        wr_addr_d = wr_addr_q;
        d_in_d    = d_in_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    rda_d   = instr_rs1;
                    rdb_d   = instr_rs2;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Preload A and the shift count so SHL can iterate in place
                opa_d    = d_out_a;
                opb_d    = d_out_b;
                result_d = d_out_a;
                carry_d  = 1'b0;
                count_d  = d_out_b[3:0];
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op_q)
                    OP_ADD: begin
                        result_d = sum_s[WIDTH-1:0];
                        carry_d  = sum_s[WIDTH];
                    end
                    OP_SUB: begin
                        result_d = opa_q - opb_q;
                        carry_d  = (opa_q < opb_q);
                    end
                    OP_AND: result_d = opa_q & opb_q;
                    OP_OR:  result_d = opa_q | opb_q;
                    OP_XOR: result_d = opa_q ^ opb_q;
                    OP_NOT: result_d = ~opa_q;
                    OP_SHL: begin
                        if (count_q != 4'd0) begin
                            result_d = {result_q[WIDTH-2:0], 1'b0};
                            carry_d  = result_q[WIDTH-1];
                            count_d  = count_q - 4'd1;
                            if (count_q == 4'd1) begin
                                state_d = S_WB;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end else begin
                            result_d = result_q;
                        end
                    end
                    OP_LDI: result_d = {{(WIDTH-2*AW){1'b0}}, rs1_q, rs2_q};
                    default: result_d = result_q;
                endcase
                if (state_d == S_WB) begin
                    wr_addr_d = rd_q;
                    d_in_d    = result_d;
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            S_WB: begin
                flag_z_d = (d_in_q == {WIDTH{1'b0}});
                flag_c_d = carry_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            count_q   <= 4'd0;
            rda_q     <= '0;
            rdb_q     <= '0;
            wr_addr_q <= '0;
            d_in_q    <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            rda_q     <= rda_d;
            rdb_q     <= rdb_d;
            wr_addr_q <= wr_addr_d;
            d_in_q    <= d_in_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
        end
    end

    // Write strobe is masked by reset so an aborted instruction never lands
    assign instr_ready = (state_q == S_IDLE);
    assign wr          = (state_q == S_WB) & ~reset;
    assign done        = (state_q == S_WB) & ~reset;
    assign rd_addr_a   = rda_q;
    assign rd_addr_b   = rdb_q;
    assign wr_addr     = wr_addr_q;
    assign d_in        = d_in_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule
